// File: rtl/alu_seq_pkg.sv
// Shared ALU class / ALUOp codes and sequencer state types; the codes are also used by the
// ALUcontrol decoder, so any change here must be mirrored there.
package alu_seq_pkg;

    localparam logic [3:0] ALU_CLS_ADD  = 4'd0;
    localparam logic [3:0] ALU_CLS_ADDU = 4'd1;
    localparam logic [3:0] ALU_CLS_ADDI = 4'd2;
    localparam logic [3:0] ALU_CLS_SUB  = 4'd3;
    localparam logic [3:0] ALU_CLS_SUBU = 4'd4;
    localparam logic [3:0] ALU_CLS_AND  = 4'd5;
    localparam logic [3:0] ALU_CLS_SLT  = 4'd6;
    localparam logic [3:0] ALU_CLS_SLL  = 4'd7;
    localparam logic [3:0] ALU_CLS_SRL  = 4'd8;
    localparam logic [3:0] ALU_CLS_SRA  = 4'd9;
    localparam logic [3:0] ALU_CLS_SLLV = 4'd10;
    localparam logic [3:0] ALU_CLS_SRAV = 4'd11;
    localparam logic [3:0] ALU_CLS_BEQ  = 4'd12;
    localparam logic [3:0] ALU_CLS_BNE  = 4'd13;
    localparam logic [3:0] ALU_CLS_BLE  = 4'd14;
    localparam logic [3:0] ALU_CLS_BGT  = 4'd15;

    localparam logic [3:0] ALUOP_NOP     = 4'd0;
    localparam logic [3:0] ALUOP_ADD     = 4'd1;
    localparam logic [3:0] ALUOP_SUB     = 4'd2;
    localparam logic [3:0] ALUOP_AND     = 4'd3;
    localparam logic [3:0] ALUOP_SLT     = 4'd4;
    localparam logic [3:0] ALUOP_SH_LOAD = 4'd5;
    localparam logic [3:0] ALUOP_SLL     = 4'd6;
    localparam logic [3:0] ALUOP_SRL     = 4'd7;
    localparam logic [3:0] ALUOP_SRA     = 4'd8;
    localparam logic [3:0] ALUOP_SLLV    = 4'd9;
    localparam logic [3:0] ALUOP_SRAV    = 4'd10;
    localparam logic [3:0] ALUOP_SH_READ = 4'd11;
    localparam logic [3:0] ALUOP_CMP_BEQ = 4'd12;
    localparam logic [3:0] ALUOP_CMP_BNE = 4'd13;
    localparam logic [3:0] ALUOP_CMP_BLE = 4'd14;
    localparam logic [3:0] ALUOP_CMP_BGT = 4'd15;

    localparam int GAP_W = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SH_LOAD,
        ST_SH_WAIT,
        ST_SH_SHIFT,
        ST_SH_READ,
        ST_CMP,
        ST_CMP_SAMPLE,
        ST_FIN
    } state_e;

    typedef enum logic [1:0] {
        PATH_NONE,
        PATH_EXEC,
        PATH_SHIFT,
        PATH_BRANCH
    } path_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Control <-> sequencer bundle: start/class request, logic_unit flags in, ALUOp and status out.
// master drives requests and flags, slave is the sequencer.
interface alu_op_sequencer_if #(
    parameter int OP_W    = 4,
    parameter int CLASS_W = 4
);
    logic               start;
    logic [CLASS_W-1:0] op_class;
    logic               OVERFLOW;
    logic               ZERO;
    logic               Update_UC;
    logic [OP_W-1:0]    ALUOp;
    logic               ALUOut_wr;
    logic               busy;
    logic               done;
    logic               branch_taken;
    logic               ovf_exc;

    modport master (
        output start, op_class, OVERFLOW, ZERO, Update_UC,
        input  ALUOp, ALUOut_wr, busy, done, branch_taken, ovf_exc
    );

    modport slave (
        input  start, op_class, OVERFLOW, ZERO, Update_UC,
        output ALUOp, ALUOut_wr, busy, done, branch_taken, ovf_exc
    );
endinterface

// File: rtl/alu_cls_decode.sv
// Combinational class decode: execution path, class-specific ALUOp and overflow-trap flag.
// Zero latency, no handshake.
module alu_cls_decode
    import alu_seq_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int CLASS_W = 4
) (
    input  logic [CLASS_W-1:0] cls_i,
    output path_e              path_o,
    output logic [OP_W-1:0]    op_o,
    output logic               ovf_chk_o
);

    always_comb begin
        path_o    = PATH_NONE;
        op_o      = OP_W'(ALUOP_NOP);
        ovf_chk_o = 1'b0;
        case (cls_i)
            CLASS_W'(ALU_CLS_ADD):  begin path_o = PATH_EXEC;   op_o = OP_W'(ALUOP_ADD); ovf_chk_o = 1'b1; end
            CLASS_W'(ALU_CLS_ADDU): begin path_o = PATH_EXEC;   op_o = OP_W'(ALUOP_ADD); end
            CLASS_W'(ALU_CLS_ADDI): begin path_o = PATH_EXEC;   op_o = OP_W'(ALUOP_ADD); ovf_chk_o = 1'b1; end
            CLASS_W'(ALU_CLS_SUB):  begin path_o = PATH_EXEC;   op_o = OP_W'(ALUOP_SUB); ovf_chk_o = 1'b1; end
            CLASS_W'(ALU_CLS_SUBU): begin path_o = PATH_EXEC;   op_o = OP_W'(ALUOP_SUB); end
            CLASS_W'(ALU_CLS_AND):  begin path_o = PATH_EXEC;   op_o = OP_W'(ALUOP_AND); end
            CLASS_W'(ALU_CLS_SLT):  begin path_o = PATH_EXEC;   op_o = OP_W'(ALUOP_SLT); end
            CLASS_W'(ALU_CLS_SLL):  begin path_o = PATH_SHIFT;  op_o = OP_W'(ALUOP_SLL); end
            CLASS_W'(ALU_CLS_SRL):  begin path_o = PATH_SHIFT;  op_o = OP_W'(ALUOP_SRL); end
            CLASS_W'(ALU_CLS_SRA):  begin path_o = PATH_SHIFT;  op_o = OP_W'(ALUOP_SRA); end
            CLASS_W'(ALU_CLS_SLLV): begin path_o = PATH_SHIFT;  op_o = OP_W'(ALUOP_SLLV); end
            CLASS_W'(ALU_CLS_SRAV): begin path_o = PATH_SHIFT;  op_o = OP_W'(ALUOP_SRAV); end
            CLASS_W'(ALU_CLS_BEQ):  begin path_o = PATH_BRANCH; op_o = OP_W'(ALUOP_CMP_BEQ); end
            CLASS_W'(ALU_CLS_BNE):  begin path_o = PATH_BRANCH; op_o = OP_W'(ALUOP_CMP_BNE); end
            CLASS_W'(ALU_CLS_BLE):  begin path_o = PATH_BRANCH; op_o = OP_W'(ALUOP_CMP_BLE); end
            CLASS_W'(ALU_CLS_BGT):  begin path_o = PATH_BRANCH; op_o = OP_W'(ALUOP_CMP_BGT); end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues the ALUOp sequence for one instruction class; start->done 2 (exec), 3 (branch), 4+SHIFT_GAP (shift).
// No queuing: start is only accepted in IDLE, otherwise dropped.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OP_W      = 4,
    parameter int CLASS_W   = 4,
    parameter int SHIFT_GAP = 1
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.slave bus
);

    state_e             state_q, state_d;
    logic [CLASS_W-1:0] cls_q, cls_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               br_q, br_d;
    logic               ovf_q, ovf_d;

    logic [CLASS_W-1:0] dec_cls;
    path_e              dec_path;
    logic [OP_W-1:0]    dec_op;
    logic               dec_ovf_chk;

    logic [OP_W-1:0]    alu_op;
    logic               alu_wr;
    logic               busy;
    logic               done;
    logic               branch_taken;
    logic               ovf_exc;

    logic               unused_zero;
    assign unused_zero = bus.ZERO;

    // In IDLE the live request is decoded to pick a path; afterwards the latched class drives ALUOp.
    assign dec_cls = (state_q == ST_IDLE) ? bus.op_class : cls_q;

    alu_cls_decode #(
        .OP_W    (OP_W),
        .CLASS_W (CLASS_W)
    ) u_decode (
        .cls_i     (dec_cls),
        .path_o    (dec_path),
        .op_o      (dec_op),
        .ovf_chk_o (dec_ovf_chk)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cls_q   <= '0;
            gap_q   <= '0;
            br_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            gap_q   <= gap_d;
            br_q    <= br_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        gap_d   = gap_q;
        br_d    = br_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                br_d  = 1'b0;
                ovf_d = 1'b0;
                if (bus.start) begin
                    cls_d = bus.op_class;
                    case (dec_path)
                        PATH_EXEC:   state_d = ST_EXEC;
                        PATH_SHIFT:  state_d = ST_SH_LOAD;
                        PATH_BRANCH: state_d = ST_CMP;
                        default:     state_d = ST_FIN;
                    endcase
                end
            end
            ST_EXEC: begin
                ovf_d   = dec_ovf_chk && bus.OVERFLOW;
                state_d = ST_FIN;
            end
            ST_SH_LOAD: begin
                gap_d   = GAP_W'(SHIFT_GAP - 1);
                state_d = ST_SH_WAIT;
            end
            ST_SH_WAIT: begin
                if (gap_q == '0) begin
                    state_d = ST_SH_SHIFT;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            ST_SH_SHIFT:   state_d = ST_SH_READ;
            ST_SH_READ:    state_d = ST_FIN;
            ST_CMP:        state_d = ST_CMP_SAMPLE;
            ST_CMP_SAMPLE: begin
                br_d    = bus.Update_UC;
                state_d = ST_FIN;
            end
            ST_FIN:        state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_op       = OP_W'(ALUOP_NOP);
        alu_wr       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        branch_taken = 1'b0;
        ovf_exc      = 1'b0;
        case (state_q)
            ST_EXEC: begin
                alu_op = dec_op;
                busy   = 1'b1;
                // A trapping overflow turns the write into an exception instead.
                alu_wr = !(dec_ovf_chk && bus.OVERFLOW);
            end
            ST_SH_LOAD: begin
                alu_op = OP_W'(ALUOP_SH_LOAD);
                busy   = 1'b1;
            end
            ST_SH_WAIT: busy = 1'b1;
            ST_SH_SHIFT: begin
                alu_op = dec_op;
                busy   = 1'b1;
            end
            ST_SH_READ: begin
                alu_op = OP_W'(ALUOP_SH_READ);
                alu_wr = 1'b1;
                busy   = 1'b1;
            end
            ST_CMP, ST_CMP_SAMPLE: begin
                alu_op = dec_op;
                busy   = 1'b1;
            end
            ST_FIN: begin
                done         = 1'b1;
                branch_taken = br_q;
                ovf_exc      = ovf_q;
            end
            default: ;
        endcase
    end

    assign bus.ALUOp        = alu_op;
    assign bus.ALUOut_wr    = alu_wr;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.branch_taken = branch_taken;
    assign bus.ovf_exc      = ovf_exc;

endmodule
